alu_seq: RTL
============

Name: alu_seq

Overview:
Registered, parametrised successor to the team's combinational 4-bit ALU. It keeps the eight base operations and the CO/OVF/N/Z flag semantics, widens the opcode to 4 bits, and adds carry-chained add/subtract, shifts/rotate and a multi-cycle unsigned multiply. Flags live in an internal register that feeds the ADC/SBC carry-in. A START/BUSY/DONE handshake lets the processor datapath stall on multi-cycle operations.

Parameters:
W, 4, operand/result width; power of two, W >= 2
SHW, $clog2(W), shift-amount width (derived, not overridden)

Ports:
CLK  input  1  clock, rising-edge active
RST  input  1  reset; one clock; reset is asynchronous and active-high
START  input  1  operation request, sampled at the CLK edge
CONTROL  input  4  opcode, sampled with START
A  input  W  operand A, sampled with START
B  input  W  operand B (shift amount = B[SHW-1:0]), sampled with START
C  output  W  registered result
CO  output  1  registered carry flag
OVF  output  1  registered overflow flag
N  output  1  registered negative flag
Z  output  1  registered zero flag
BUSY  output  1  high while a multiply is in progress
DONE  output  1  one-cycle pulse: C and flags are updated

Behaviour:
- Reset (async, RST=1): C=0, CO=0, OVF=0, N=0, Z=0, BUSY=0, DONE=0, multiplier state cleared. Reset mid-multiply aborts the operation and no DONE is produced.
- Accept: START=1 and BUSY=0 at a CLK edge. START while BUSY=1 is ignored with no queuing. A, B and CONTROL are latched at accept, so later changes have no effect.
- Opcodes:
  - 0000 ADD, 0001 SUB A-B, 0010 SUB B-A, 0011 BIC (~A&B), 0100 AND, 0101 OR, 0110 XOR, 0111 XNOR. These keep their existing semantics.
  - 1000 ADC, 1001 SBC, 1010 LSL, 1011 LSR, 1100 ASR, 1101 ROR, 1110 MUL, 1111 NOP.
- Single-cycle ops (all except MUL): C and flags are written at the accept edge. DONE=1 for the following cycle. Back-to-back accepts every cycle are allowed.
- ADD/SUB flags:
  - CO is the carry-out of A+B or A+~B+1, so SUB CO=1 means no borrow.
  - OVF is signed overflow, using the same sign-bit rules as today.
- ADC = A+B+CO_reg; SBC = A+~B+CO_reg. CO_reg is the flag value before this op. OVF uses the same rules as ADD/SUB.
- Logic ops: CO=0, OVF=0.
- Shifts and ROR use s = B[SHW-1:0]:
  - s=0: C=A, CO=0.
  - Otherwise CO = the last bit shifted out. For ROR, CO = new C[W-1].
  - ASR replicates A[W-1].
  - OVF=0 for all shifts.
- MUL: unsigned shift-add over W iterations.
  - BUSY rises in the cycle after the accept edge and stays high for W cycles.
  - C, the flags and BUSY=0 are written at the final iteration edge. DONE pulses the next cycle.
  - Total latency from accept to DONE is W+1 cycles.
  - C = low W bits of the product. CO = OVF = (high W bits != 0).
- N = C[W-1] and Z = (C==0) for every op except NOP.
- NOP: C and all flags hold; DONE still pulses.
- DONE is never high while BUSY=1. C and flags hold between operations.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD..OP_NOP (4-bit localparams);
  - flag bit indices for any packed flag vector.
- One sub-module, alu_mul_seq: the shift-add multiplier.
  - Parameter W.
  - Ports CLK, RST, GO, A, B, P[2W-1:0], BUSY, FIN.
  - FIN pulses at the final iteration edge.
- alu_seq holds the combinational op mux, the result/flag registers and the DONE logic.

Test Plan:
- W=4, ADD A=7 B=1 -> C=8, N=1, OVF=1, CO=0, Z=0; DONE high exactly one cycle after accept.
- SUB A=3 B=3 -> C=0, Z=1, CO=1. Then ADC A=F B=0 -> C=0, CO=1, Z=1 (uses CO_reg=1). Then SBC A=5 B=2 with CO_reg=1 -> C=3, CO=1.
- LSL A=9 B=1 -> C=2, CO=1. ASR A=8 B=2 -> C=E, N=1, CO=0. ROR A=1 B=1 -> C=8, CO=1. LSR A=6 B=0 -> C=6, CO=0.
- MUL A=5 B=3 -> BUSY high 4 cycles, C=F, CO=0, DONE 5 cycles after accept. MUL A=6 B=3 -> C=2, CO=OVF=1. START and operand changes during BUSY are ignored.
- Assert RST during the 2nd MUL iteration -> all outputs 0 immediately (async). No DONE follows. A new ADD accepted after reset release completes normally.
- NOP after any op -> C and flags unchanged, DONE pulses. Back-to-back single-cycle ops on consecutive cycles -> a DONE each cycle with correct results.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, flag bit positions and flag packing for alu_seq
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_RSB  = 4'b0010;
  localparam logic [3:0] OP_BIC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_ADC  = 4'b1000;
  localparam logic [3:0] OP_SBC  = 4'b1001;
  localparam logic [3:0] OP_LSL  = 4'b1010;
  localparam logic [3:0] OP_LSR  = 4'b1011;
  localparam logic [3:0] OP_ASR  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam int NFLAGS   = 4;
  localparam int FLAG_CO  = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_N   = 2;
  localparam int FLAG_Z   = 3;

  function automatic logic [NFLAGS-1:0] make_flags(input logic co, input logic ovf,
                                                   input logic n, input logic z);
    logic [NFLAGS-1:0] f;
    f           = '0;
    f[FLAG_CO]  = co;
    f[FLAG_OVF] = ovf;
    f[FLAG_N]   = n;
    f[FLAG_Z]   = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - unsigned shift-add multiplier, one partial product per clock
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           GO,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] P,
  output logic           BUSY,
  output logic           FIN
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] addend;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  count;
  logic           busy;

  // P is the accumulator after the step taken at the coming edge, so on the
  // final iteration it is already the full product for the parent to capture.
  assign addend = mplier[0] ? mcand : '0;
  assign P      = acc + addend;
  assign BUSY   = busy;
  assign FIN    = busy && (count == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (GO) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, A};
      mplier <= B;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= P;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (count == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with carry chaining, shifts and a sequential multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [3:0]   CONTROL,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic         CO,
  output logic         OVF,
  output logic         N,
  output logic         Z,
  output logic         BUSY,
  output logic         DONE
);

  localparam int SHW = $clog2(W);
  localparam logic [SHW:0] WIDTH_L = W[SHW:0];

  logic              accept;
  logic              mul_go;
  logic              mul_busy;
  logic              mul_fin;
  logic [2*W-1:0]    mul_p;
  logic              mul_hi;
  logic [SHW-1:0]    s;
  logic [W-1:0]      add_x;
  logic [W-1:0]      add_y;
  logic              add_cin;
  logic [W:0]        sum;
  logic [W:0]        lsl_full;
  logic [W:0]        lsr_full;
  logic [W:0]        asr_full;
  logic [W-1:0]      ror;
  logic [W-1:0]      res;
  logic              res_co;
  logic              res_ovf;
  logic [NFLAGS-1:0] flags;

  assign accept = START && !mul_busy;
  assign mul_go = accept && (CONTROL == OP_MUL);
  assign mul_hi = |mul_p[2*W-1:W];
  assign s      = B[SHW-1:0];

  // One spare bit on each shift catches the last bit shifted out as the carry.
  assign lsl_full = {1'b0, A} << s;
  assign lsr_full = {A, 1'b0} >> s;
  assign asr_full = $signed({A, 1'b0}) >>> s;
  assign ror      = (A >> s) | (A << (WIDTH_L - {1'b0, s}));
  assign sum      = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

  alu_mul_seq #(.W(W)) u_mul (
    .CLK  (CLK),
    .RST  (RST),
    .GO   (mul_go),
    .A    (A),
    .B    (B),
    .P    (mul_p),
    .BUSY (mul_busy),
    .FIN  (mul_fin)
  );

  always_comb begin
    add_x   = A;
    add_y   = B;
    add_cin = 1'b0;
    case (CONTROL)
      OP_SUB: begin add_y = ~B; add_cin = 1'b1; end
      OP_RSB: begin add_x = B; add_y = ~A; add_cin = 1'b1; end
      OP_ADC: add_cin = flags[FLAG_CO];
      OP_SBC: begin add_y = ~B; add_cin = flags[FLAG_CO]; end
      default: ;
    endcase
  end

  always_comb begin
    res     = '0;
    res_co  = 1'b0;
    res_ovf = 1'b0;
    case (CONTROL)
      OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC: begin
        res     = sum[W-1:0];
        res_co  = sum[W];
        res_ovf = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);
      end
      OP_BIC:  res = ~A & B;
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_XNOR: res = ~(A ^ B);
      OP_LSL:  begin res = lsl_full[W-1:0]; res_co = lsl_full[W]; end
      OP_LSR:  begin res = lsr_full[W:1];   res_co = lsr_full[0]; end
      OP_ASR:  begin res = asr_full[W:1];   res_co = asr_full[0]; end
      OP_ROR:  begin res = ror; res_co = (s != '0) && ror[W-1]; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      C     <= '0;
      flags <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (mul_fin) begin
        C     <= mul_p[W-1:0];
        flags <= make_flags(mul_hi, mul_hi, mul_p[W-1], mul_p[W-1:0] == '0);
        DONE  <= 1'b1;
      end else if (accept && (CONTROL != OP_MUL)) begin
        DONE <= 1'b1;
        if (CONTROL != OP_NOP) begin
          C     <= res;
          flags <= make_flags(res_co, res_ovf, res[W-1], res == '0);
        end
      end
    end
  end

  assign CO   = flags[FLAG_CO];
  assign OVF  = flags[FLAG_OVF];
  assign N    = flags[FLAG_N];
  assign Z    = flags[FLAG_Z];
  assign BUSY = mul_busy;

endmodule
